// File: rtl/modul_suma_delta_pkg.sv
// Shared types and helpers for the delta decoder.
//   buf_state_t : occupancy of the 2-entry output buffer
//   entry_t     : one buffered output sample {sum, idx, ovf} at default widths
//   smax/smin   : two's-complement extremes of a given width (low w bits valid)
package modul_suma_delta_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_t;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_CNT_WIDTH = 16;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]     sum;
    logic [DEF_CNT_WIDTH-1:0] idx;
    logic                     ovf;
  } entry_t;

  function automatic logic [63:0] smax(input int unsigned w);
    smax = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] smin(input int unsigned w);
    smin = 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/modul_suma_delta_if.sv
// Handshake bundle for the delta decoder.
//   in_valid/in_ready/in_delta/in_first : delta stream into the decoder
//   out_valid/out_ready/out_sum/out_idx/out_ovf : reconstructed samples out
// slave  : decoder view
// master : source/sink (environment) view
interface modul_suma_delta_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_delta;
  logic                 in_first;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_sum;
  logic [CNT_WIDTH-1:0] out_idx;
  logic                 out_ovf;

  modport slave (
    input  in_valid, in_delta, in_first, out_ready,
    output in_ready, out_valid, out_sum, out_idx, out_ovf
  );

  modport master (
    output in_valid, in_delta, in_first, out_ready,
    input  in_ready, out_valid, out_sum, out_idx, out_ovf
  );
endinterface

// File: rtl/modul_buffer_2.sv
// Generic 2-entry valid/ready buffer with a registered upstream ready.
//   clk, rst           : clock, synchronous active-high reset
//   i_valid/o_ready    : upstream handshake (o_ready registered)
//   i_data             : upstream data
//   o_valid/i_ready    : downstream handshake
//   o_data             : head entry, held stable while stalled
module modul_buffer_2
  import modul_suma_delta_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  buf_state_t    r_state;
  buf_state_t    w_state_nxt;
  logic          r_ready;
  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_valid && r_ready;
  assign w_pop   = (r_state != BUF_EMPTY) && i_ready;
  assign o_valid = (r_state != BUF_EMPTY);
  assign o_ready = r_ready;
  assign o_data  = r_head;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUF_EMPTY: if (w_push) w_state_nxt = BUF_ONE;
      BUF_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = BUF_TWO;
        else if (w_pop && !w_push) w_state_nxt = BUF_EMPTY;
      end
      BUF_TWO:   if (w_pop) w_state_nxt = BUF_ONE;
      default:   w_state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BUF_EMPTY;
      r_ready <= 1'b1;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Ready follows the next state so it is low exactly while full.
      r_ready <= (w_state_nxt != BUF_TWO);
      case (r_state)
        BUF_EMPTY: if (w_push) r_head <= i_data;
        BUF_ONE: begin
          if (w_push && w_pop) r_head <= i_data;
          else if (w_push)     r_tail <= i_data;
        end
        BUF_TWO:   if (w_pop) r_head <= r_tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/modul_suma_delta.sv
// Delta decoder: reconstructs absolute samples as running sum of deltas.
//   clk, rst : clock, synchronous active-high reset
//   bus      : modul_suma_delta_if.slave
//              in_*  delta stream (in_first seeds the accumulator, idx 0)
//              out_* {sum, idx, ovf} through a 2-entry buffer
// Optional macro MODUL_SUMA_DELTA_SAT_EN: non-first additions saturate to the
// signed range instead of wrapping; out_ovf flags the overflow either way.
module modul_suma_delta
  import modul_suma_delta_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  modul_suma_delta_if.slave bus
);

  localparam int unsigned  DW    = WIDTH + CNT_WIDTH + 1;
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(smin(WIDTH));

  logic [WIDTH-1:0]     r_acc;
  logic [CNT_WIDTH-1:0] r_idx;
  logic [WIDTH-1:0]     w_sum_raw;
  logic                 w_ovf_raw;
  logic [WIDTH-1:0]     w_acc_nxt;
  logic [CNT_WIDTH-1:0] w_idx_nxt;
  logic                 w_ovf;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_out_valid;
  logic [DW-1:0]        w_head;

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_sum_raw = r_acc + bus.in_delta;
  assign w_ovf_raw = (r_acc[WIDTH-1] == bus.in_delta[WIDTH-1]) &&
                     (w_sum_raw[WIDTH-1] != r_acc[WIDTH-1]);

  always_comb begin
    w_acc_nxt = w_sum_raw;
    w_idx_nxt = r_idx + CNT_WIDTH'(1);
    w_ovf     = w_ovf_raw;
`ifdef MODUL_SUMA_DELTA_SAT_EN
    // Overflow direction follows the operands' common sign.
    if (w_ovf_raw) w_acc_nxt = r_acc[WIDTH-1] ? L_MIN : L_MAX;
`endif
    if (bus.in_first) begin
      w_acc_nxt = bus.in_delta;
      w_idx_nxt = '0;
      w_ovf     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  modul_buffer_2 #(.DW(DW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.in_valid),
    .o_ready (w_in_ready),
    .i_data  ({w_acc_nxt, w_idx_nxt, w_ovf}),
    .o_valid (w_out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_head)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = w_head[DW-1 -: WIDTH];
  assign bus.out_idx   = w_head[CNT_WIDTH:1];
  assign bus.out_ovf   = w_head[0];

endmodule

// File: tb/tb_modul_suma_delta.sv
// Testbench for modul_suma_delta: directed scenarios plus a random stream,
// checked against a queue-based reference model using integer arithmetic.
module tb_modul_suma_delta;
  import modul_suma_delta_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modul_suma_delta_if #(.WIDTH(8), .CNT_WIDTH(16)) bus ();

  modul_suma_delta #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  entry_t      q[$];
  int          m_acc;
  int unsigned m_idx;
  logic        stall;
  entry_t      held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t cur();
    return {bus.out_sum, bus.out_idx, bus.out_ovf};
  endfunction

  // Reference: signed integer running sum, overflow = result outside [-128,127].
  task automatic model_push(input logic [7:0] d, input logic f);
    int   s;
    logic o;
    if (f) begin
      m_acc = int'($signed(d));
      m_idx = 0;
      o     = 1'b0;
    end else begin
      s = m_acc + int'($signed(d));
      o = (s > 127) || (s < -128);
`ifdef MODUL_SUMA_DELTA_SAT_EN
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
`else
      s = ((s + 384) % 256) - 128;
`endif
      m_acc = s;
      m_idx = (m_idx + 1) % 65536;
    end
    q.push_back({8'(m_acc), 16'(m_idx), o});
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic ordy);
    logic xfer;
    logic acc;
    bus.in_valid  = v;
    bus.in_delta  = d;
    bus.in_first  = f;
    bus.out_ready = ordy;
    #1;
    chk("occ_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("occ_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    if (stall) chk("stable", 32'(cur()), 32'(held));
    xfer = bus.out_valid && ordy;
    acc  = v && bus.in_ready;
    if (xfer && q.size() > 0) begin
      chk("head", 32'(cur()), 32'(q[0]));
      void'(q.pop_front());
    end
    stall = bus.out_valid && !ordy;
    held  = cur();
    if (acc) model_push(d, f);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_acc = 0;
    m_idx = 0;
    stall = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_sum",   32'(bus.out_sum), 32'd0);
    chk("rst_idx",   32'(bus.out_idx), 32'd0);
    chk("rst_ovf",   32'(bus.out_ovf), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_delta  = '0;
    bus.in_first  = 1'b0;
    bus.out_ready = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    do_reset();

    // Seed and deltas with free-flowing output
    step(1'b1, 8'd10, 1'b1, 1'b1);
    chk("seed_sum", 32'(bus.out_sum), 32'd10);
    chk("seed_idx", 32'(bus.out_idx), 32'd0);
    step(1'b1, 8'd5, 1'b0, 1'b1);
    chk("d5_sum", 32'(bus.out_sum), 32'd15);
    step(1'b1, 8'hFD, 1'b0, 1'b1);
    chk("dm3_sum", 32'(bus.out_sum), 32'd12);
    chk("dm3_idx", 32'(bus.out_idx), 32'd2);
    step(1'b1, 8'd0, 1'b0, 1'b1);
    chk("d0_sum", 32'(bus.out_sum), 32'd12);
    chk("d0_idx", 32'(bus.out_idx), 32'd3);
    chk("d0_ovf", 32'(bus.out_ovf), 32'd0);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Backpressure: third word must wait for space
    step(1'b1, 8'd1, 1'b1, 1'b0);
    step(1'b1, 8'd2, 1'b0, 1'b0);
    chk("bp_full", 32'(bus.in_ready), 32'd0);
    step(1'b1, 8'd3, 1'b0, 1'b0);
    chk("bp_hold", 32'(bus.out_sum), 32'd1);
    step(1'b1, 8'd3, 1'b0, 1'b1);
    step(1'b1, 8'd3, 1'b0, 1'b1);
    chk("bp_third", 32'(bus.out_sum), 32'd6);
    chk("bp_third_idx", 32'(bus.out_idx), 32'd2);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Overflow
    step(1'b1, 8'd120, 1'b1, 1'b1);
    step(1'b1, 8'd10, 1'b0, 1'b1);
`ifdef MODUL_SUMA_DELTA_SAT_EN
    chk("ovf_sum", 32'(bus.out_sum), 32'd127);
`else
    chk("ovf_sum", 32'(bus.out_sum), 32'h82);
`endif
    chk("ovf_flag", 32'(bus.out_ovf), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
`ifdef MODUL_SUMA_DELTA_SAT_EN
    chk("ovf_next", 32'(bus.out_sum), 32'd126);
`else
    chk("ovf_next", 32'(bus.out_sum), 32'h81);
`endif
    chk("ovf_next_flag", 32'(bus.out_ovf), 32'd0);

    // Restart mid-stream
    step(1'b1, 8'hCE, 1'b1, 1'b1);
    chk("rs_sum", 32'(bus.out_sum), 32'hCE);
    chk("rs_idx", 32'(bus.out_idx), 32'd0);
    step(1'b1, 8'd1, 1'b0, 1'b1);
    chk("rs2_sum", 32'(bus.out_sum), 32'hCF);
    chk("rs2_idx", 32'(bus.out_idx), 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Reset while full
    step(1'b1, 8'd9, 1'b0, 1'b0);
    step(1'b1, 8'd9, 1'b0, 1'b0);
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    do_reset();
    step(1'b1, 8'd7, 1'b0, 1'b1);
    chk("post_rst_sum", 32'(bus.out_sum), 32'd7);
    chk("post_rst_idx", 32'(bus.out_idx), 32'd1);

    // Random stream
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
